// File: rtl/window_stream_offset.sv
// Streaming 1-D stencil window: for each frame element x[i] emits the triple
// (x[i-DIST], x[i], x[i+DIST]) with pad/clamp substitution at the frame edges.
module window_stream_offset #(
  parameter int           N     = 64,
  parameter int           DIST  = 1,
  parameter int           SIZE  = 1024,
  parameter int           BMODE = 0,
  parameter logic [N-1:0] PAD   = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_c,
  output logic [N-1:0] out_m,
  output logic [N-1:0] out_p,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  // state | meaning
  // FILL  | accepting x[0..DIST-1], nothing emitted yet
  // RUN   | each accepted x[j] loads output element j-DIST
  // DRAIN | input closed; emit the last DIST elements, then wait for the final transfer
  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int            CW       = $clog2(SIZE + 1);
  localparam int            WL       = 2 * DIST;
  localparam logic [CW-1:0] DIST_C   = CW'(DIST);
  localparam logic [CW-1:0] FILL_END = CW'(DIST - 1);
  localparam logic [CW-1:0] LAST_C   = CW'(SIZE - 1);
  localparam logic [CW-1:0] SIZE_C   = CW'(SIZE);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [N-1:0]  win [WL];
  logic [N-1:0]  edge_first;
  logic [N-1:0]  edge_last;

  logic          slot_free;
  logic          in_xfer;
  logic          out_xfer;
  logic          load;
  logic [N-1:0]  bnd_lo;
  logic [N-1:0]  bnd_hi;
  logic [N-1:0]  nxt_m;
  logic [N-1:0]  nxt_p;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state != DRAIN) && slot_free;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // In DRAIN a new element is loaded whenever the output slot frees up, until all SIZE are issued.
  assign load = ((state == RUN) && in_xfer) ||
                ((state == DRAIN) && slot_free && (out_cnt != SIZE_C));

  assign bnd_lo = (BMODE != 0) ? edge_first : PAD;
  assign bnd_hi = (BMODE != 0) ? edge_last  : PAD;

  // The window is read before this cycle's shift: win[DIST-1] is x[i], win[2*DIST-1] is x[i-DIST].
  assign nxt_m = (out_cnt >= DIST_C) ? win[WL-1] : bnd_lo;
  assign nxt_p = (state == DRAIN) ? bnd_hi : in_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= FILL;
      in_cnt     <= '0;
      out_cnt    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_c      <= '0;
      out_m      <= '0;
      out_p      <= '0;
      edge_first <= '0;
      edge_last  <= '0;
      for (int k = 0; k < WL; k++) win[k] <= '0;
    end else begin
      if (in_xfer || ((state == DRAIN) && load)) begin
        win[0] <= in_data;
        for (int k = 1; k < WL; k++) win[k] <= win[k-1];
      end

      if (load) begin
        out_valid <= 1'b1;
        out_c     <= win[DIST-1];
        out_m     <= nxt_m;
        out_p     <= nxt_p;
        out_last  <= (out_cnt == LAST_C);
        out_cnt   <= out_cnt + ONE_C;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end

      case (state)
        FILL: begin
          if (in_xfer) begin
            in_cnt <= in_cnt + ONE_C;
            if (in_cnt == '0) edge_first <= in_data;
            if (in_cnt == FILL_END) state <= RUN;
          end
        end
        RUN: begin
          if (in_xfer) begin
            in_cnt <= in_cnt + ONE_C;
            if (in_cnt == LAST_C) begin
              edge_last <= in_data;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Hold off the next frame until the final element has actually left.
          if ((out_cnt == SIZE_C) && out_xfer) begin
            state   <= FILL;
            in_cnt  <= '0;
            out_cnt <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_window_stream_offset.sv
// Bench for window_stream_offset: three instances (pad DIST=1, clamp DIST=1, pad DIST=2)
// checked against a frame-level reference model plus fixed vector tables.
module tb_window_stream_offset;

  localparam int          SIZE = 8;
  localparam logic [15:0] PAD  = 16'hFFFF;
  localparam int          NRND = 6;

  typedef struct {
    logic [15:0] din;
    logic [15:0] m0;
    logic [15:0] c;
    logic [15:0] p0;
    logic [15:0] m1;
    logic [15:0] p1;
    logic        last;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn      [3];
  logic [15:0] in_data   [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] out_c     [3];
  logic [15:0] out_m     [3];
  logic [15:0] out_p     [3];
  logic        out_last  [3];
  logic        out_valid [3];
  logic        out_ready [3];

  window_stream_offset #(.N(16), .DIST(1), .SIZE(SIZE), .BMODE(0), .PAD(PAD)) dut_a (
    .clk(clk), .rstn(rstn[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_c(out_c[0]), .out_m(out_m[0]), .out_p(out_p[0]),
    .out_last(out_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));

  window_stream_offset #(.N(16), .DIST(1), .SIZE(SIZE), .BMODE(1), .PAD(PAD)) dut_b (
    .clk(clk), .rstn(rstn[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_c(out_c[1]), .out_m(out_m[1]), .out_p(out_p[1]),
    .out_last(out_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));

  window_stream_offset #(.N(16), .DIST(2), .SIZE(SIZE), .BMODE(0), .PAD(PAD)) dut_c (
    .clk(clk), .rstn(rstn[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_c(out_c[2]), .out_m(out_m[2]), .out_p(out_p[2]),
    .out_last(out_last[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

  int          checks = 0;
  int          errors = 0;
  vec_t        tbl [SIZE];

  logic [15:0] hist  [3][$];
  logic [15:0] src   [3][$];
  logic [15:0] cap_c [3][$];
  logic [15:0] cap_m [3][$];
  logic [15:0] cap_p [3][$];
  logic        cap_l [3][$];

  int          out_idx  [3];
  int          frames   [3];
  bit          pend     [3];
  logic [15:0] pend_c   [3];
  bit          stall    [3];
  logic [15:0] st_c     [3];
  logic [15:0] st_m     [3];
  logic [15:0] st_p     [3];
  logic        st_l     [3];
  bit          rst_seen [3];
  bit          acc      [3];
  int          vpat     [3];
  bit          rnd_rdy  [3];
  bit          tog      [3];

  function automatic int dist_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic bit clamp_of(input int d);
    return (d == 1);
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h", name, d, act, exp);
    end
  endtask

  // Reference: triple for element i from the words of the current frame accepted so far.
  task automatic check_out(input int d);
    int          i;
    int          dd;
    bit          ok;
    logic [15:0] em;
    logic [15:0] ep;
    i  = out_idx[d];
    dd = dist_of(d);
    ok = (i + dd < SIZE) ? (i + dd < hist[d].size()) : (hist[d].size() == SIZE);
    chk("out_data_avail", d, 32'(ok), 1);
    if (ok) begin
      em = (i >= dd) ? hist[d][i-dd] : (clamp_of(d) ? hist[d][0] : PAD);
      ep = (i + dd < SIZE) ? hist[d][i+dd] : (clamp_of(d) ? hist[d][SIZE-1] : PAD);
      chk("out_c", d, 32'(out_c[d]), 32'(hist[d][i]));
      chk("out_m", d, 32'(out_m[d]), 32'(em));
      chk("out_p", d, 32'(out_p[d]), 32'(ep));
      chk("out_last", d, 32'(out_last[d]), 32'(i == SIZE - 1));
    end
    cap_c[d].push_back(out_c[d]);
    cap_m[d].push_back(out_m[d]);
    cap_p[d].push_back(out_p[d]);
    cap_l[d].push_back(out_last[d]);
    out_idx[d]++;
    if (out_idx[d] == SIZE) begin
      hist[d].delete();
      out_idx[d] = 0;
      frames[d]++;
    end
  endtask

  task automatic monitor();
    for (int d = 0; d < 3; d++) begin
      acc[d] = 1'b0;
      if (!rstn[d]) begin
        hist[d].delete();
        out_idx[d]  = 0;
        pend[d]     = 1'b0;
        stall[d]    = 1'b0;
        rst_seen[d] = 1'b1;
      end else begin
        if (rst_seen[d]) begin
          chk("rst_valid", d, 32'(out_valid[d]), 0);
          chk("rst_last", d, 32'(out_last[d]), 0);
          chk("rst_data", d, {out_m[d], out_c[d] | out_p[d]}, 0);
          rst_seen[d] = 1'b0;
        end
        if (stall[d]) begin
          chk("hold_valid", d, 32'(out_valid[d]), 1);
          chk("hold_c", d, 32'(out_c[d]), 32'(st_c[d]));
          chk("hold_mp", d, {out_m[d], out_p[d]}, {st_m[d], st_p[d]});
          chk("hold_last", d, 32'(out_last[d]), 32'(st_l[d]));
        end
        if (pend[d]) begin
          chk("lat_valid", d, 32'(out_valid[d]), 1);
          chk("lat_c", d, 32'(out_c[d]), 32'(pend_c[d]));
          pend[d] = 1'b0;
        end
        chk("in_ready", d, 32'(in_ready[d]),
            32'((hist[d].size() < SIZE) && (!out_valid[d] || out_ready[d])));
        if (out_valid[d] && out_ready[d]) check_out(d);
        stall[d] = out_valid[d] && !out_ready[d];
        st_c[d]  = out_c[d];
        st_m[d]  = out_m[d];
        st_p[d]  = out_p[d];
        st_l[d]  = out_last[d];
        if (in_valid[d] && in_ready[d]) begin
          acc[d] = 1'b1;
          if (hist[d].size() >= dist_of(d)) begin
            pend[d]   = 1'b1;
            pend_c[d] = hist[d][hist[d].size() - dist_of(d)];
          end
          hist[d].push_back(in_data[d]);
        end
      end
    end
  endtask

  task automatic drive();
    for (int d = 0; d < 3; d++) begin
      if (rnd_rdy[d]) out_ready[d] = 1'($urandom_range(0, 1));
      tog[d] = !tog[d];
      if (src[d].size() > 0) begin
        in_data[d] = src[d][0];
        case (vpat[d])
          0:       in_valid[d] = 1'b1;
          1:       in_valid[d] = tog[d];
          default: in_valid[d] = 1'($urandom_range(0, 1));
        endcase
      end else begin
        in_valid[d] = 1'b0;
        in_data[d]  = '0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    for (int d = 0; d < 3; d++)
      if (acc[d] && src[d].size() > 0) void'(src[d].pop_front());
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit busy(input bit until_idle);
    for (int d = 0; d < 3; d++) begin
      if (src[d].size() > 0) return 1'b1;
      if (until_idle && hist[d].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run(input int bound, input bit until_idle);
    int n;
    n = 0;
    drive();
    while (n < bound && busy(until_idle)) begin
      cycle();
      n++;
    end
    chk("run_timeout", 0, 32'(busy(until_idle)), 0);
  endtask

  task automatic clear_caps();
    for (int d = 0; d < 3; d++) begin
      cap_c[d].delete();
      cap_m[d].delete();
      cap_p[d].delete();
      cap_l[d].delete();
    end
  endtask

  task automatic check_table(input int d);
    chk("tbl_count", d, 32'(cap_c[d].size()), SIZE);
    if (cap_c[d].size() >= SIZE) begin
      for (int k = 0; k < SIZE; k++) begin
        chk("tbl_c", d, 32'(cap_c[d][k]), 32'(tbl[k].c));
        chk("tbl_m", d, 32'(cap_m[d][k]), 32'(clamp_of(d) ? tbl[k].m1 : tbl[k].m0));
        chk("tbl_p", d, 32'(cap_p[d][k]), 32'(clamp_of(d) ? tbl[k].p1 : tbl[k].p0));
        chk("tbl_last", d, 32'(cap_l[d][k]), 32'(tbl[k].last));
      end
    end
  endtask

  initial begin
    tbl[0] = '{16'd1, 16'hFFFF, 16'd1, 16'd2,    16'd1, 16'd2, 1'b0};
    tbl[1] = '{16'd2, 16'd1,    16'd2, 16'd3,    16'd1, 16'd3, 1'b0};
    tbl[2] = '{16'd3, 16'd2,    16'd3, 16'd4,    16'd2, 16'd4, 1'b0};
    tbl[3] = '{16'd4, 16'd3,    16'd4, 16'd5,    16'd3, 16'd5, 1'b0};
    tbl[4] = '{16'd5, 16'd4,    16'd5, 16'd6,    16'd4, 16'd6, 1'b0};
    tbl[5] = '{16'd6, 16'd5,    16'd6, 16'd7,    16'd5, 16'd7, 1'b0};
    tbl[6] = '{16'd7, 16'd6,    16'd7, 16'd8,    16'd6, 16'd8, 1'b0};
    tbl[7] = '{16'd8, 16'd7,    16'd8, 16'hFFFF, 16'd7, 16'd8, 1'b1};

    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b1;
      out_idx[d] = 0; frames[d] = 0; pend[d] = 1'b0; stall[d] = 1'b0;
      rst_seen[d] = 1'b0; acc[d] = 1'b0; vpat[d] = 0; rnd_rdy[d] = 1'b0; tog[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rstn[d] = 1'b1;

    // Pad and clamp boundary tables on the same stream.
    clear_caps();
    for (int k = 0; k < SIZE; k++) begin
      src[0].push_back(tbl[k].din);
      src[1].push_back(tbl[k].din);
    end
    run(200, 1'b1);
    check_table(0);
    check_table(1);

    // DIST=2 with gappy input and random back-pressure.
    clear_caps();
    vpat[2] = 1; rnd_rdy[2] = 1'b1;
    for (int k = 1; k <= SIZE; k++) src[2].push_back(16'(k));
    run(400, 1'b1);
    chk("d2_count", 2, 32'(cap_c[2].size()), SIZE);
    for (int k = 0; k < cap_c[2].size(); k++) chk("d2_order", 2, 32'(cap_c[2][k]), 32'(k + 1));
    vpat[2] = 0; rnd_rdy[2] = 1'b0; out_ready[2] = 1'b1;

    // Back-to-back frames: no mixing across the frame wrap.
    clear_caps();
    for (int k = 1; k <= SIZE; k++) src[0].push_back(16'(k));
    for (int k = 11; k <= 10 + SIZE; k++) src[0].push_back(16'(k));
    run(400, 1'b1);
    chk("wrap_count", 0, 32'(cap_c[0].size()), 2 * SIZE);
    if (cap_c[0].size() == 2 * SIZE) begin
      chk("wrap_p_last", 0, 32'(cap_p[0][SIZE-1]), 32'(PAD));
      chk("wrap_first", 0, {cap_m[0][SIZE], cap_c[0][SIZE]}, {PAD, 16'd11});
      chk("wrap_first_p", 0, 32'(cap_p[0][SIZE]), 32'd12);
    end

    // Reset after five inputs of a frame; the partial frame must vanish.
    for (int k = 1; k <= 5; k++) src[0].push_back(16'(k));
    run(100, 1'b0);
    rstn[0] = 1'b0;
    cycle();
    rstn[0] = 1'b1;
    clear_caps();
    for (int k = 0; k < SIZE; k++) src[0].push_back(tbl[k].din);
    run(200, 1'b1);
    check_table(0);

    // Ten-cycle stall right after the first output.
    clear_caps();
    out_ready[0] = 1'b0;
    for (int k = 0; k < SIZE; k++) src[0].push_back(tbl[k].din);
    drive();
    for (int n = 0; n < 50 && !out_valid[0]; n++) cycle();
    chk("stall_seen", 0, 32'(out_valid[0]), 1);
    repeat (10) cycle();
    chk("stall_c", 0, 32'(out_c[0]), 1);
    chk("stall_accepted", 0, 32'(hist[0].size()), 2);
    out_ready[0] = 1'b1;
    run(200, 1'b1);
    check_table(0);

    // Random frames on all three instances at once.
    for (int r = 0; r < NRND; r++) begin
      for (int d = 0; d < 3; d++) begin
        vpat[d] = 2; rnd_rdy[d] = 1'b1;
        for (int k = 0; k < SIZE; k++) src[d].push_back(16'($urandom_range(0, 65535)));
      end
      run(1000, 1'b1);
    end
    for (int d = 0; d < 3; d++) begin
      rnd_rdy[d] = 1'b0; out_ready[d] = 1'b1; vpat[d] = 0;
    end

    chk("frames", 0, 32'(frames[0]), 5 + NRND);
    chk("frames", 1, 32'(frames[1]), 1 + NRND);
    chk("frames", 2, 32'(frames[2]), 1 + NRND);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
